// File: rtl/gate_exerciser_pkg.sv
// Shared definitions for the gate exerciser and the gate benches that reuse it.
// Holds FSM state encodings, reference 2-input truth tables and a width helper.
// Nothing here carries state; it is imported by the exerciser and its counter.
package gate_exerciser_pkg;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    // Reference 2-input truth tables: bit i is the gate output for input vector i
    localparam logic [3:0] EXPECT_AND2 = 4'b1000;
    localparam logic [3:0] EXPECT_OR2  = 4'b1110;
    localparam logic [3:0] EXPECT_XOR2 = 4'b0110;

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gate_exerciser_settle_counter.sv
// Settle timer: loadable up-counter flagging hit when it reaches SETTLE-1.
// Latency: hit reflects the registered count, one cycle after clr/inc take effect.
// No backpressure: clr dominates inc, the count simply wraps if left running.
module gate_exerciser_settle_counter
    import gate_exerciser_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int            CW   = cnt_width(SETTLE);
    localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear has priority over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit = (cnt_q == LAST);

endmodule

// File: rtl/gate_exerciser.sv
// Gate exerciser: walks every input vector of an N_IN-input gate, holds each
// SETTLE cycles, samples dut_out and scores it against the EXPECT truth table.
// No backpressure: start is only honoured in IDLE; all outputs are registered.
module gate_exerciser
    import gate_exerciser_pkg::*;
#(
    parameter int                      N_IN   = 2,
    parameter int                      SETTLE = 2,
    parameter logic [(2**N_IN)-1:0]    EXPECT = EXPECT_AND2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              dut_out,
    output logic [N_IN-1:0]   vec,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_cnt,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_valid
);

    localparam int EW = N_IN + 1;

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [EW-1:0]   err_cnt_q, err_cnt_d;
    logic [N_IN-1:0] first_err_vec_q, first_err_vec_d;
    logic            first_err_valid_q, first_err_valid_d;

    logic            cnt_clr;
    logic            cnt_inc;
    logic            cnt_hit;
    logic            mismatch;

    // Settle timer runs only while in WAIT and is cleared everywhere else,
    // so every WAIT visit starts counting from zero.
    gate_exerciser_settle_counter #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .hit   (cnt_hit)
    );

    assign mismatch = (dut_out != EXPECT[vec_q]);

    // FSM and scoreboard next-state logic
    always_comb begin
        state_d           = state_q;
        vec_d             = vec_q;
        busy_d            = busy_q;
        done_d            = 1'b0;
        pass_d            = pass_q;
        err_cnt_d         = err_cnt_q;
        first_err_vec_d   = first_err_vec_q;
        first_err_valid_d = first_err_valid_q;
        cnt_clr           = 1'b1;
        cnt_inc           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                vec_d  = '0;
                busy_d = 1'b0;
                if (start) begin
                    // Accepting a run wipes the previous run's results
                    state_d           = ST_WAIT;
                    busy_d            = 1'b1;
                    pass_d            = 1'b0;
                    err_cnt_d         = '0;
                    first_err_vec_d   = '0;
                    first_err_valid_d = 1'b0;
                end
            end

            ST_WAIT: begin
                cnt_clr = 1'b0;
                cnt_inc = 1'b1;
                if (cnt_hit) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                if (mismatch) begin
                    err_cnt_d = err_cnt_q + EW'(1);
                    if (!first_err_valid_q) begin
                        first_err_vec_d   = vec_q;
                        first_err_valid_d = 1'b1;
                    end
                end
                // Incrementing the all-ones vector wraps to 0, which is
                // exactly the value vec must show while in FINISH.
                vec_d = vec_q + N_IN'(1);
                if (&vec_q) begin
                    state_d = ST_FINISH;
                    done_d  = 1'b1;
                    pass_d  = (err_cnt_d == '0);
                end else begin
                    state_d = ST_WAIT;
                end
            end

            ST_FINISH: begin
                // start is deliberately ignored here
                state_d = ST_IDLE;
                vec_d   = '0;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                vec_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any run without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_IDLE;
            vec_q             <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            err_cnt_q         <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            vec_q             <= vec_d;
            busy_q            <= busy_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
            err_cnt_q         <= err_cnt_d;
            first_err_vec_q   <= first_err_vec_d;
            first_err_valid_q <= first_err_valid_d;
        end
    end

    assign vec             = vec_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_vec   = first_err_vec_q;
    assign first_err_valid = first_err_valid_q;

endmodule

// File: doc/gate_exerciser.md
# gate_exerciser

Self-checking stimulus/response stage for the combinational gate blocks. It drives every input vector of an N-input gate in ascending order and holds each vector for a programmable settle time. It then samples the gate output and compares it with a parameterised truth table, reporting a mismatch count, the first failing vector and a pass flag. The block sits directly around the gate: `vec` feeds the gate inputs, and the gate output returns on `dut_out`.

## Interface
- `N_IN`, 2: number of gate inputs; legal range 1..6.
- `SETTLE`, 2: cycles each vector is held before sampling; must be ≥1.
- `EXPECT`, 4'b1000: expected truth table, width 2^N_IN. Bit i is the expected `dut_out` for `vec == i`. The default is AND.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a run; sampled only in IDLE.
- `dut_out`  in  1  gate output under test.
- `vec`  out  N_IN  registered gate input vector.
- `busy`  out  1  high from the start edge until FINISH is exited.
- `done`  out  1  one-cycle pulse at end of run.
- `pass`  out  1  1 if the last completed run had zero mismatches.
- `err_cnt`  out  N_IN+1  mismatch count of current/last run; saturation is impossible.
- `first_err_vec`  out  N_IN  vector of the first mismatch.
- `first_err_valid`  out  1  `first_err_vec` is meaningful.

## Operation
- States: IDLE, WAIT, SAMPLE, FINISH.
- IDLE:
  - `vec`=0, `busy`=0.
  - On `start`=1, go to WAIT with settle counter=0 and `vec`=0.
  - Also clear `err_cnt`, `pass`, `first_err_valid` and `first_err_vec`.
- WAIT: the settle counter increments each cycle. When counter == SETTLE-1, go to SAMPLE.
- SAMPLE:
  - Compare `dut_out` with `EXPECT[vec]`.
  - On mismatch, increment `err_cnt`. If `first_err_valid`=0, also capture `first_err_vec`=`vec` and set `first_err_valid`.
  - If `vec` is all-ones, go to FINISH. Otherwise `vec`+1, clear the counter and go to WAIT.
- FINISH:
  - `done`=1 and `busy`=1; `pass` is set to (final `err_cnt`==0).
  - `vec` returns to 0. Next state is IDLE unconditionally.
- `start` outside IDLE is ignored, including in the FINISH cycle. A held-high `start` relaunches only after IDLE is re-entered.
- `pass`, `err_cnt`, `first_err_*` hold their values after FINISH until the next accepted `start`.
- Reset (async, any state):
  - State=IDLE; all outputs 0, including `pass`.
  - An in-flight run is abandoned with no `done`.
  - Operation resumes on the first edge after `rst_n` deasserts.

## Timing
- Reset values: `vec`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `first_err_vec`=0, `first_err_valid`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Per vector: SETTLE cycles of WAIT plus 1 cycle of SAMPLE. `dut_out` is sampled at the edge ending SAMPLE, SETTLE+1 edges after `vec` changed.
- Run length: `start` is sampled at edge E0, and `done` is high for the one cycle between edge E0+2^N_IN·(SETTLE+1) and the following edge.
  - Default parameters: done after E12, back in IDLE after E13.
- `busy` rises after E0 and falls at the edge leaving FINISH.
- Back-to-back runs: minimum `start` spacing is run length + 2 cycles (FINISH, then one IDLE cycle).

## Structure
- Shared header `gate_defs.vh` holds:
  - state encodings (IDLE=0, WAIT=1, SAMPLE=2, FINISH=3);
  - default `EXPECT` constants for AND/OR/XOR 2-input tables, reused by other gate benches.
- One natural sub-module: `settle_counter`, a loadable up-counter with a `hit` output at SETTLE-1.
- The FSM and scoreboard registers stay in `gate_exerciser`.

## Test plan
- Correct 2-input AND, defaults, 1-cycle `start` pulse -> `vec` steps 0,1,2,3 with each held 3 cycles; done after 12 edges; `pass`=1, `err_cnt`=0, `first_err_valid`=0.
- OR gate wired, EXPECT=AND -> mismatches at vec 1 and 2; `err_cnt`=2, `first_err_vec`=1, `pass`=0.
- `dut_out` stuck at 1 -> `err_cnt`=3, `first_err_vec`=0, `pass`=0; results hold 20 cycles after done.
- `start` held high for the whole run, plus an extra pulse at cycle 5 -> exactly one `done` per run. A new `start` after IDLE clears `err_cnt` and reruns.
- `rst_n` low at cycle 7 mid-run -> all outputs 0 immediately (before the next edge); no `done`; a later `start` completes a clean run.
- N_IN=3, EXPECT=8'h80, SETTLE=1, correct 3-input AND -> vec 0..7, done after 16 edges, `pass`=1.
